// File: rtl/mem_req_initiator.sv
// Byte-serial MOV/MOC initiator: splits byte/halfword/word accesses into byte transfers.
// Optional MEM_REQ_SIGN_EXT_EN adds SGN for sign-extended byte/halfword loads.
module mem_req_initiator #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ,
`ifdef MEM_REQ_SIGN_EXT_EN
  input  logic              SGN,
`endif
  input  logic              RW,
  input  logic [1:0]        SIZE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       WDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [31:0]       RDATA,
  output logic              MOV,
  output logic              MRW,
  output logic [ADDR_W-1:0] MADDR,
  output logic [7:0]        MDOUT,
  input  logic [7:0]        MDIN,
  input  logic              MOC,
  output logic [2:0]        fsm_state
);

  // Handshake: MOV rises with MADDR/MRW/MDOUT stable and stays high until MOC is
  // seen high; MOC must then fall before the next byte's MOV may rise.
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_FINISH, S_FAULT
  } state_t;

  localparam logic [7:0] TIMER_INIT = TIMEOUT[7:0];

  state_t              state, state_nxt;
  logic                rw_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rbuf_q;
  logic [31:0]         rdata_q;
  logic [31:0]         rdata_ext;
  logic [1:0]          idx_q, idx_nxt;
  logic [7:0]          timer_q, timer_nxt;
  logic [1:0]          last_idx;
  logic                misaligned;
  logic                capture;
  logic                load_rdata;
  logic                sgn_eff;

  assign misaligned = (SIZE == 2'b11) ||
                      ((SIZE == 2'b01) && ADDR[0]) ||
                      ((SIZE == 2'b10) && (ADDR[1:0] != 2'b00));

  // Index of the final byte: 0, 1 or 3 for byte, halfword, word.
  assign last_idx = {size_q[1], size_q[1] | size_q[0]};

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx_q;
    timer_nxt  = timer_q;
    capture    = 1'b0;
    load_rdata = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (REQ) begin
          idx_nxt   = 2'd0;
          state_nxt = misaligned ? S_FAULT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_nxt = TIMER_INIT;
        state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (MOC) begin
          capture   = rw_q;
          timer_nxt = TIMER_INIT;
          state_nxt = S_WAIT_LO;
        end else if (timer_q <= 8'd1) begin
          state_nxt = S_FAULT;
        end else begin
          timer_nxt = timer_q - 8'd1;
        end
      end
      S_WAIT_LO: begin
        if (!MOC) begin
          if (idx_q == last_idx) begin
            load_rdata = rw_q;
            state_nxt  = S_FINISH;
          end else begin
            idx_nxt   = idx_q + 2'd1;
            state_nxt = S_ISSUE;
          end
        end else if (timer_q <= 8'd1) begin
          state_nxt = S_FAULT;
        end else begin
          timer_nxt = timer_q - 8'd1;
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      S_FAULT:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

`ifdef MEM_REQ_SIGN_EXT_EN
  logic sgn_q;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sgn_q <= 1'b0;
    end else if (state == S_IDLE && REQ) begin
      sgn_q <= SGN;
    end
  end
  assign sgn_eff = sgn_q;
`else
  assign sgn_eff = 1'b0;
`endif

  always_comb begin
    unique case (size_q)
      2'b00:   rdata_ext = {{24{sgn_eff & rbuf_q[7]}},  rbuf_q[7:0]};
      2'b01:   rdata_ext = {{16{sgn_eff & rbuf_q[15]}}, rbuf_q[15:0]};
      default: rdata_ext = rbuf_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      idx_q   <= 2'd0;
      timer_q <= 8'd0;
      rw_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rbuf_q  <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state   <= state_nxt;
      idx_q   <= idx_nxt;
      timer_q <= timer_nxt;
      if (state == S_IDLE && REQ) begin
        rw_q    <= RW;
        size_q  <= SIZE;
        addr_q  <= ADDR;
        wdata_q <= WDATA;
        rbuf_q  <= 32'd0;
      end
      if (capture) rbuf_q[{idx_q, 3'b000} +: 8] <= MDIN;
      if (load_rdata) rdata_q <= rdata_ext;
    end
  end

  // Bus outputs decode straight from registered state so they hold stable across WAIT_HI.
  assign BUSY      = (state != S_IDLE);
  assign DONE      = (state == S_FINISH);
  assign ERR       = (state == S_FAULT);
  assign MOV       = (state == S_ISSUE) || (state == S_WAIT_HI);
  assign MRW       = rw_q;
  assign MADDR     = addr_q + ADDR_W'(idx_q);
  assign MDOUT     = wdata_q[{idx_q, 3'b000} +: 8];
  assign RDATA     = rdata_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed bench for mem_req_initiator with a behavioural byte RAM answering MOV with MOC.
`timescale 1ns/1ps
module tb_mem_req_initiator;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 15;

  logic        clk, rst, req, rw;
  logic [1:0]  size;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        busy, done, err, mov, mrw;
  logic [31:0] rdata;
  logic [7:0]  maddr, mdout, mdin;
  logic [2:0]  fsm_state;
  logic        moc = 1'b0;
`ifdef MEM_REQ_SIGN_EXT_EN
  logic        sgn;
`endif

  mem_req_initiator #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(clk), .RESET(rst), .REQ(req),
`ifdef MEM_REQ_SIGN_EXT_EN
    .SGN(sgn),
`endif
    .RW(rw), .SIZE(size), .ADDR(addr), .WDATA(wdata),
    .BUSY(busy), .DONE(done), .ERR(err), .RDATA(rdata),
    .MOV(mov), .MRW(mrw), .MADDR(maddr), .MDOUT(mdout),
    .MDIN(mdin), .MOC(moc), .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: MOC rises the cycle after MOV, lasting stretch_len cycles at stretch_addr.
  logic [7:0] mem [0:255];
  logic       ram_en;
  logic [7:0] stretch_addr;
  int         stretch_len;
  int         moc_left = 0;

  assign mdin = mov ? mem[maddr] : 8'hEE;

  always @(posedge clk) begin
    if (moc) begin
      if (moc_left > 1) moc_left <= moc_left - 1;
      else moc <= 1'b0;
    end else if (mov && ram_en) begin
      moc      <= 1'b1;
      moc_left <= (maddr == stretch_addr) ? stretch_len : 1;
    end
  end

  // Observation counters, sampled on the falling edge
  int          done_cnt = 0, err_cnt = 0, mov_cnt = 0, rd_cap_cnt = 0, wr_cnt = 0;
  logic [15:0] wr_log [0:63];

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (mov) mov_cnt++;
    if (mov && moc && mrw) rd_cap_cnt++;
    if (mov && moc && !mrw && wr_cnt < 64) begin
      wr_log[wr_cnt] = {maddr, mdout};
      wr_cnt++;
    end
  end

  // Scoreboard
  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Driver tasks (entered on a falling edge)
  task automatic start_req(input logic r, input logic [1:0] s, input logic [7:0] a,
                           input logic [31:0] d);
    req = 1'b1; rw = r; size = s; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; rw = ~r; size = 2'b11; addr = ~a; wdata = 32'hDEADBEEF;
  endtask

  task automatic wait_end(input int budget, output int lat);
    lat = 1;
    while (!(done || err) && lat < budget) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic access(input string tag, input logic r, input logic [1:0] s,
                        input logic [7:0] a, input logic [31:0] d, input int exp_lat,
                        input logic exp_err, input logic [31:0] exp_rd);
    int lat, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_req(r, s, a, d);
    check({tag, "_busy"}, busy, 1);
    wait_end(64, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_done"}, done, !exp_err);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_mov_end"}, mov, 0);
    check({tag, "_rdata"}, rdata, exp_rd);
    @(negedge clk);
    check({tag, "_idle"}, busy, 0);
    @(negedge clk);
    check({tag, "_ndone"}, done_cnt - d0, {31'd0, !exp_err});
    check({tag, "_nerr"}, err_cnt - e0, {31'd0, exp_err});
  endtask

  task automatic check_writes(input string tag, input int base);
    check({tag, "_wcnt"}, wr_cnt - base, exp_q.size());
    while (exp_q.size() > 0) begin
      check({tag, "_wr"}, wr_log[base], exp_q.pop_front());
      base++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, m0, c0, d0, e0;
    logic found;
    rst = 1'b1; req = 1'b0; rw = 1'b0; size = 2'b00; addr = 8'h00; wdata = 32'd0;
`ifdef MEM_REQ_SIGN_EXT_EN
    sgn = 1'b0;
`endif
    ram_en = 1'b1; stretch_addr = 8'h00; stretch_len = 1;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'hFE] = 8'h80; mem[8'hFF] = 8'h7F; mem[8'h05] = 8'h9C;
    mem[8'h20] = 8'h11; mem[8'h21] = 8'h22; mem[8'h22] = 8'h33; mem[8'h23] = 8'h44;
    repeat (3) @(negedge clk);

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mov", mov, 0);
    check("rst_mrw", mrw, 0);
    check("rst_maddr", maddr, 0);
    check("rst_mdout", mdout, 0);
    check("rst_rdata", rdata, 0);
    check("rst_state", fsm_state, 0);
    rst = 1'b0;
    @(negedge clk);

    // Word store: ascending byte sequence, 13-cycle latency
    base = wr_cnt;
    exp_q.push_back(16'h10D4); exp_q.push_back(16'h11C3);
    exp_q.push_back(16'h12B2); exp_q.push_back(16'h13A1);
    access("st_word", 1'b0, 2'b10, 8'h10, 32'hA1B2C3D4, 13, 1'b0, 32'h0);
    check_writes("st_word", base);

    access("ld_half", 1'b1, 2'b01, 8'hFE, 32'h0, 7, 1'b0, 32'h00007F80);
    access("ld_byte", 1'b1, 2'b00, 8'h05, 32'h0, 4, 1'b0, 32'h0000009C);
`ifdef MEM_REQ_SIGN_EXT_EN
    sgn = 1'b1;
    last_rd = 32'hFFFFFF80;
`else
    last_rd = 32'h00000080;
`endif
    access("ld_byte_fe", 1'b1, 2'b00, 8'hFE, 32'h0, 4, 1'b0, last_rd);
`ifdef MEM_REQ_SIGN_EXT_EN
    sgn = 1'b0;
`endif

    // Misalignment and illegal size: ERR the cycle after acceptance, no MOV
    m0 = mov_cnt;
    access("ld_word_mis", 1'b1, 2'b10, 8'h02, 32'h0, 1, 1'b1, last_rd);
    access("ld_size11", 1'b1, 2'b11, 8'h00, 32'h0, 1, 1'b1, last_rd);
    access("st_half_odd", 1'b0, 2'b01, 8'h31, 32'h1234, 1, 1'b1, last_rd);
    check("mis_nomov", mov_cnt - m0, 0);

    // Silent RAM: one ISSUE cycle plus TIMEOUT WAIT_HI cycles of MOV
    ram_en = 1'b0;
    m0 = mov_cnt;
    access("timeout", 1'b1, 2'b00, 8'h40, 32'h0, 2 + TIMEOUT, 1'b1, last_rd);
    check("timeout_movcyc", mov_cnt - m0, 1 + TIMEOUT);
    ram_en = 1'b1;
    base = wr_cnt;
    exp_q.push_back(16'h415A);
    access("st_after_tmo", 1'b0, 2'b00, 8'h41, 32'hFFFFFF5A, 4, 1'b0, last_rd);
    check_writes("st_after_tmo", base);

    // MOC held for 3 extra cycles on byte 0 of a word load
    stretch_addr = 8'h20; stretch_len = 4;
    m0 = mov_cnt; c0 = rd_cap_cnt;
    access("ld_stretch", 1'b1, 2'b10, 8'h20, 32'h0, 16, 1'b0, 32'h44332211);
    check("stretch_movcyc", mov_cnt - m0, 8);
    check("stretch_caps", rd_cap_cnt - c0, 4);
    stretch_len = 1;

    // Reset during WAIT_HI of byte 2 of a word store
    start_req(1'b0, 2'b10, 8'h50, 32'h01020304);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (mov && maddr == 8'h52 && fsm_state == 3'd2) found = 1'b1;
      else @(negedge clk);
    end
    check("rst_mid_found", found, 1);
    d0 = done_cnt; e0 = err_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_mov", mov, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_state", fsm_state, 0);
    check("rst_mid_rdata", rdata, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_ndone", done_cnt - d0, 0);
    check("rst_mid_nerr", err_cnt - e0, 0);
    base = wr_cnt;
    exp_q.push_back(16'h6077);
    access("st_after_rst", 1'b0, 2'b00, 8'h60, 32'h00000077, 4, 1'b0, 32'h0);
    check_writes("st_after_rst", base);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
